mips_fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline: owns the PC, drives a variable-latency instruction-memory request handshake, and produces the IF/ID pipeline register consumed by decode. A one-entry skid buffer captures an instruction that returns while decode is stalled, so no memory response is ever lost. Branch/jump redirects and flushes from later stages are applied here.

---
 rtl/mips_fetch_stage_pkg.sv | 22 ++
 rtl/mips_fetch_stage_skid_buf.sv | 50 +++++
 rtl/mips_fetch_stage.sv | 158 +++++++++++++++
 tb/tb_mips_fetch_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: reset PC, NOP word,
// fetch FSM state encodings and a word-alignment helper.
package mips_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // FETCH: request outstanding at pc.
    // BUFFERED: skid buffer holds a word, no request issued.
    // DRAIN: waiting out a stale request whose data will be dropped.
    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_BUFFERED = 2'd1,
        ST_DRAIN    = 2'd2
    } fetch_state_e;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mips_fetch_stage_skid_buf.sv
// One-entry {pc, instr} skid buffer that catches an instruction returning
// from memory while decode is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        full,
    output logic [31:0] entry_pc,
    output logic [31:0] entry_instr
);

    logic        full_q,  full_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;

    // Next-entry logic: a load captures a new word, otherwise clear empties it.
    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (load) begin
            full_d  = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end else if (clear) begin
            full_d = 1'b0;
        end
    end

    // Entry registers with synchronous reset to empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= 32'h0;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full        = full_q;
    assign entry_pc    = pc_q;
    assign entry_instr = instr_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs the variable-latency imem
// handshake, applies redirects/flushes and produces the IF/ID register.
module mips_fetch_stage
    import mips_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;

    logic         skid_load, skid_clear, skid_full;
    logic [31:0]  skid_pc, skid_instr;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_pc    (pc_q),
        .load_instr (imem_rdata),
        .full       (skid_full),
        .entry_pc   (skid_pc),
        .entry_instr(skid_instr)
    );

    // Fetch FSM, PC and IF/ID next-state; redirect beats flush beats normal flow.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        drain_addr_d    = drain_addr_q;
        ifid_valid_d    = ifid_valid_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;
        skid_load       = 1'b0;
        skid_clear      = 1'b0;

        if (redirect_valid) begin
            // New target; any word returning now or sitting in the skid is stale.
            pc_d       = align_word(redirect_pc);
            skid_clear = 1'b1;
            case (state_q)
                ST_FETCH: begin
                    if (!imem_ready) begin
                        state_d      = ST_DRAIN;
                        drain_addr_d = pc_q;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_DRAIN: state_d = imem_ready ? ST_FETCH : ST_DRAIN;
                default:  state_d = ST_FETCH;
            endcase
            if (flush) begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end else if (flush) begin
            // Squash IF/ID; a returning word is dropped so pc is refetched.
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_clear   = 1'b1;
            case (state_q)
                ST_DRAIN: state_d = imem_ready ? ST_FETCH : ST_DRAIN;
                default:  state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_plus4;
                        if (!stall) begin
                            ifid_valid_d    = 1'b1;
                            ifid_pc_d       = pc_q;
                            ifid_pc_plus4_d = pc_plus4;
                            ifid_instr_d    = imem_rdata;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = ST_BUFFERED;
                        end
                    end
                end
                ST_BUFFERED: begin
                    if (!stall && skid_full) begin
                        ifid_valid_d    = 1'b1;
                        ifid_pc_d       = skid_pc;
                        ifid_pc_plus4_d = skid_pc + 32'd4;
                        ifid_instr_d    = skid_instr;
                        skid_clear      = 1'b1;
                        state_d         = ST_FETCH;
                    end else if (!stall) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ready) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_FETCH;
            pc_q            <= RESET_PC;
            drain_addr_q    <= RESET_PC;
            ifid_valid_q    <= 1'b0;
            ifid_pc_q       <= 32'h0;
            ifid_pc_plus4_q <= 32'h0;
            ifid_instr_q    <= NOP_INSTR;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            drain_addr_q    <= drain_addr_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
        end
    end

    // The stale address is held during DRAIN so the memory sees a stable request.
    assign imem_req      = !reset && (state_q != ST_BUFFERED);
    assign imem_addr     = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign ifid_valid    = ifid_valid_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_instr    = ifid_instr_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: a wait-state memory responder,
// an IF/ID scoreboard monitor and one task per scenario.
module tb_mips_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;

    int checks = 0;
    int errors = 0;
    int ws     = 0;
    int cnt    = 0;
    bit mon_en = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = 32'h0;
    logic [31:0] exp_q[$];

    mips_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_instr    (ifid_instr)
    );

    always #10 clk = ~clk;

    // Memory: answers a request after ws wait cycles with addr ^ KEY.
    always @(negedge clk) begin
        #2;
        if (reset || !imem_req) begin
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            cnt        = 0;
        end else if (cnt >= ws) begin
            imem_ready = 1'b1;
            imem_rdata = imem_addr ^ KEY;
            cnt        = 0;
        end else begin
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            cnt++;
        end
    end

    // Scoreboard: every newly loaded live IF/ID entry must match the queue head.
    always @(negedge clk) begin
        logic [31:0] e_pc, e_p4;
        #4;
        if (mon_en && ifid_valid && (!prev_valid || ifid_pc !== prev_pc)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ifid_unexpected: got pc %h, required no new entry", ifid_pc);
            end else begin
                e_pc = exp_q.pop_front();
                e_p4 = e_pc + 32'd4;
                if (ifid_pc !== e_pc || ifid_pc_plus4 !== e_p4 || ifid_instr !== (e_pc ^ KEY)) begin
                    errors++;
                    $display("FAIL ifid_entry: got pc %h pc4 %h instr %h, required pc %h pc4 %h instr %h",
                             ifid_pc, ifid_pc_plus4, ifid_instr, e_pc, e_p4, e_pc ^ KEY);
                end
            end
        end
        prev_valid = ifid_valid;
        prev_pc    = ifid_pc;
    end

    task automatic next_cycle();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #3;
            if (imem_ready) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no imem_ready, required one within 20 cycles", tag);
    endtask

    task automatic finish_scoreboard(input string tag);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_lost: got %0d entries never seen, required 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    // Two reset cycles, reset state checked, released; returns at drive point of first cycle.
    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        #5;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b, required 0", imem_req); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", ifid_valid); end
        checks++; if (ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h/%h, required 0/0", ifid_pc, ifid_pc_plus4); end
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h, required 0", ifid_instr); end
        @(negedge clk);
        #1;
        reset = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        ws = 0;
        do_reset();
        #2;
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("FAIL rst_first_req: got %b %h, required 1 %h", imem_req, imem_addr, RST_PC); end
    endtask

    task automatic test_zero_wait();
        ws = 0;
        do_reset();
        exp_q.push_back(32'h0040_0000);
        exp_q.push_back(32'h0040_0004);
        exp_q.push_back(32'h0040_0008);
        mon_en = 1'b1;
        #2;
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_c1: got %b, required 0", ifid_valid); end
        next_cycle();
        #2;
        checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0040_0000) begin errors++; $display("FAIL zw_valid_c2: got %b %h, required 1 00400000", ifid_valid, ifid_pc); end
        checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL zw_addr_c2: got %h, required 00400004", imem_addr); end
        next_cycle();
        next_cycle();
        #2;
        finish_scoreboard("zw");
    endtask

    task automatic test_skid_stall();
        ws = 2;
        do_reset();
        exp_q.push_back(32'h0040_0000);
        exp_q.push_back(32'h0040_0004);
        exp_q.push_back(32'h0040_0008);
        mon_en = 1'b1;
        wait_ready("sk_first");
        wait_ready("sk_second");
        checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL sk_ready_addr: got %h, required 00400004", imem_addr); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #2;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sk_req_buffered: got %b, required 0", imem_req); end
            checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0040_0000) begin errors++; $display("FAIL sk_ifid_hold: got %b %h, required 1 00400000", ifid_valid, ifid_pc); end
        end
        next_cycle();
        stall = 1'b0;
        #2;
        checks++; if (imem_req !== 1'b0 || ifid_pc !== 32'h0040_0000) begin errors++; $display("FAIL sk_release: got req %b pc %h, required 0 00400000", imem_req, ifid_pc); end
        next_cycle();
        #2;
        checks++; if (ifid_pc !== 32'h0040_0004 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL sk_drain: got pc %h req %b addr %h, required 00400004 1 00400008", ifid_pc, imem_req, imem_addr); end
        wait_ready("sk_third");
        next_cycle();
        #2;
        finish_scoreboard("sk");
    endtask

    task automatic test_redirect_drain();
        ws = 3;
        do_reset();
        exp_q.push_back(32'h0040_1000);
        mon_en = 1'b1;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_1003;
        next_cycle();
        redirect_valid = 1'b0;
        #2;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rd_stale_hold: got %b %h, required 1 00400000", imem_req, imem_addr); end
        wait_ready("rd_stale");
        next_cycle();
        #2;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_1000) begin errors++; $display("FAIL rd_new_addr: got %b %h, required 1 00401000", imem_req, imem_addr); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rd_no_stale: got valid %b pc %h, required 0", ifid_valid, ifid_pc); end
        wait_ready("rd_new");
        next_cycle();
        #2;
        finish_scoreboard("rd");
    endtask

    task automatic test_flush_refetch();
        ws = 0;
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(RST_PC + 32'(4 * i));
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) next_cycle();
        checks++; if (imem_ready !== 1'b1 || imem_addr !== 32'h0040_0010) begin errors++; $display("FAIL fl_setup: got ready %b addr %h, required 1 00400010", imem_ready, imem_addr); end
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        #2;
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL fl_squash: got %b %h, required 0 00000000", ifid_valid, ifid_instr); end
        checks++; if (ifid_pc !== 32'h0040_000C || ifid_pc_plus4 !== 32'h0040_0010) begin errors++; $display("FAIL fl_pc_kept: got %h %h, required 0040000c 00400010", ifid_pc, ifid_pc_plus4); end
        checks++; if (imem_addr !== 32'h0040_0010) begin errors++; $display("FAIL fl_refetch: got %h, required 00400010", imem_addr); end
        next_cycle();
        #2;
        finish_scoreboard("fl");
    endtask

    task automatic test_pc_wrap();
        ws = 0;
        do_reset();
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        mon_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        next_cycle();
        redirect_valid = 1'b0;
        #2;
        checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_redirect: got valid %b addr %h, required 0 fffffffc", ifid_valid, imem_addr); end
        next_cycle();
        #2;
        checks++; if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wr_addr: got %h, required 00000000", imem_addr); end
        next_cycle();
        #2;
        finish_scoreboard("wr");
    endtask

    task automatic test_reset_buffered();
        ws = 0;
        do_reset();
        exp_q.push_back(32'h0040_0000);
        exp_q.push_back(32'h0040_0004);
        exp_q.push_back(32'h0040_0008);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        stall = 1'b1;
        next_cycle();
        #2;
        checks++; if (imem_req !== 1'b0 || ifid_pc !== 32'h0040_0008) begin errors++; $display("FAIL rb_buffered: got req %b pc %h, required 0 00400008", imem_req, ifid_pc); end
        finish_scoreboard("rb_pre");
        do_reset();
        exp_q.push_back(32'h0040_0000);
        mon_en = 1'b1;
        #2;
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || ifid_valid !== 1'b0) begin errors++; $display("FAIL rb_release: got req %b addr %h valid %b, required 1 %h 0", imem_req, imem_addr, ifid_valid, RST_PC); end
        next_cycle();
        #2;
        finish_scoreboard("rb");
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_skid_stall();
        test_redirect_drain();
        test_flush_refetch();
        test_pc_wrap();
        test_reset_buffered();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
